// File: rtl/conf_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conf_seq_ctrl                                                  |
// | Purpose  : Streams kernel instruction words into N_RC configuration       |
// |            register files, then replays them by driving a shared PC      |
// |            with read/clock enables.                                      |
// | Options  : CONF_SEQ_PERF_EN builds the saturating exec cycle counter;     |
// |            when undefined perf_cycles_o is tied to 0.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module conf_seq_ctrl #(
  parameter int N_RC    = 4,
  parameter int N_CREG  = 32,
  parameter int INSTR_W = 32,
  parameter int LOOP_W  = 16,
  localparam int PC_W   = $clog2(N_CREG)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_load_i,
  input  logic               cmd_exec_i,
  input  logic               abort_i,
  input  logic [PC_W-1:0]    last_pc_i,
  input  logic [LOOP_W-1:0]  loop_cnt_i,
  input  logic               instr_valid_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               instr_ready_o,
  output logic [INSTR_W-1:0] conf_instr_o,
  output logic [N_RC-1:0]    conf_we_o,
  output logic               conf_re_o,
  output logic               conf_ce_o,
  output logic [PC_W-1:0]    global_pc_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [31:0]        perf_cycles_o
);

  localparam int RC_W = (N_RC > 1) ? $clog2(N_RC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [RC_W-1:0]   rc_idx_q, rc_idx_d;
  logic [LOOP_W-1:0] iter_q, iter_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  // Final iteration index, i.e. max(loop_cnt,1)-1, so the wrap test is a plain compare.
  logic [LOOP_W-1:0] iter_last_q, iter_last_d;
  logic              beat;

  // State and counter registers; async reset returns to IDLE with all counters cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      rc_idx_q    <= '0;
      iter_q      <= '0;
      last_pc_q   <= '0;
      iter_last_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rc_idx_q    <= rc_idx_d;
      iter_q      <= iter_d;
      last_pc_q   <= last_pc_d;
      iter_last_q <= iter_last_d;
    end
  end

  // Next-state, counter update and all combinational outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rc_idx_d      = rc_idx_q;
    iter_d        = iter_q;
    last_pc_d     = last_pc_q;
    iter_last_d   = iter_last_q;
    instr_ready_o = 1'b0;
    conf_instr_o  = '0;
    conf_we_o     = '0;
    conf_re_o     = 1'b0;
    conf_ce_o     = 1'b0;
    global_pc_o   = '0;
    busy_o        = (state_q != S_IDLE);
    done_o        = 1'b0;
    beat          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_load_i) begin
          state_d   = S_LOAD;
          pc_d      = '0;
          rc_idx_d  = '0;
          last_pc_d = last_pc_i;
        end else if (cmd_exec_i) begin
          state_d     = S_EXEC;
          pc_d        = '0;
          rc_idx_d    = '0;
          iter_d      = '0;
          last_pc_d   = last_pc_i;
          iter_last_d = (loop_cnt_i == '0) ? '0 : loop_cnt_i - LOOP_W'(1);
        end
      end

      S_LOAD: begin
        // An abort in the same cycle must not let a beat through.
        instr_ready_o = ~abort_i;
        beat          = instr_valid_i & ~abort_i;
        global_pc_o   = pc_q;
        if (beat) begin
          conf_we_o    = N_RC'(1) << rc_idx_q;
          conf_ce_o    = 1'b1;
          conf_instr_o = instr_i;
          if (rc_idx_q == RC_W'(N_RC - 1)) begin
            rc_idx_d = '0;
            if (pc_q == last_pc_q) begin
              state_d = S_DONE;
              pc_d    = '0;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end else begin
            rc_idx_d = rc_idx_q + RC_W'(1);
          end
        end
      end

      S_EXEC: begin
        conf_re_o   = 1'b1;
        conf_ce_o   = 1'b1;
        global_pc_o = pc_q;
        if (pc_q == last_pc_q) begin
          pc_d = '0;
          if (iter_q == iter_last_q) begin
            state_d = S_DRAIN;
            iter_d  = '0;
          end else begin
            iter_d = iter_q + LOOP_W'(1);
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      // One extra clock-enabled cycle lets the files consume the last registered read.
      S_DRAIN: begin
        conf_ce_o = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      pc_d     = '0;
      rc_idx_d = '0;
      iter_d   = '0;
    end
  end

`ifdef CONF_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of EXEC/DRAIN cycles, cleared on the IDLE->EXEC transition.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && cmd_exec_i && !cmd_load_i) begin
      perf_d = '0;
    end else if (((state_q == S_EXEC) || (state_q == S_DRAIN)) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conf_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_conf_seq_ctrl                                               |
// | Purpose  : Directed self-checking bench for conf_seq_ctrl with a          |
// |            scoreboard of expected load beats and exec PCs.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_conf_seq_ctrl;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  pc;
    logic [31:0] instr;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_load, cmd_exec, abort_s;
  logic [4:0]  last_pc;
  logic [15:0] loop_cnt;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] conf_instr;
  logic [3:0]  conf_we;
  logic        conf_re, conf_ce;
  logic [4:0]  global_pc;
  logic        busy, done;
  logic [31:0] perf;

  int          n_err = 0;
  int          n_checks = 0;
  beat_t       beat_q[$];
  int          pc_q[$];

  conf_seq_ctrl #(
    .N_RC   (4),
    .N_CREG (32),
    .INSTR_W(32),
    .LOOP_W (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_load_i   (cmd_load),
    .cmd_exec_i   (cmd_exec),
    .abort_i      (abort_s),
    .last_pc_i    (last_pc),
    .loop_cnt_i   (loop_cnt),
    .instr_valid_i(instr_valid),
    .instr_i      (instr),
    .instr_ready_o(instr_ready),
    .conf_instr_o (conf_instr),
    .conf_we_o    (conf_we),
    .conf_re_o    (conf_re),
    .conf_ce_o    (conf_ce),
    .global_pc_o  (global_pc),
    .busy_o       (busy),
    .done_o       (done),
    .perf_cycles_o(perf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(instr_ready), 64'(0));
    chk({tag, "_instr"}, 64'(conf_instr), 64'(0));
    chk({tag, "_we"}, 64'(conf_we), 64'(0));
    chk({tag, "_re"}, 64'(conf_re), 64'(0));
    chk({tag, "_ce"}, 64'(conf_ce), 64'(0));
    chk({tag, "_pc"}, 64'(global_pc), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // Drives one accepted load beat and checks it against the scoreboard head.
  task automatic load_beat(input string tag, input logic [31:0] data);
    beat_t e;
    instr_valid = 1'b1;
    instr       = data;
    #2;
    if (beat_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = beat_q.pop_front();
      chk({tag, "_we"}, 64'(conf_we), 64'(e.we));
      chk({tag, "_pc"}, 64'(global_pc), 64'(e.pc));
      chk({tag, "_instr"}, 64'(conf_instr), 64'(e.instr));
      chk({tag, "_ce"}, 64'(conf_ce), 64'(1));
    end
    step();
    instr_valid = 1'b0;
  endtask

  // Checks one EXEC cycle against the scoreboard head, then advances.
  task automatic exec_cycle(input string tag);
    int p;
    #2;
    chk({tag, "_re"}, 64'(conf_re), 64'(1));
    chk({tag, "_ce"}, 64'(conf_ce), 64'(1));
    if (pc_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      p = pc_q.pop_front();
      chk({tag, "_pc"}, 64'(global_pc), 64'(p));
    end
    step();
  endtask

  initial begin
    logic [31:0] exp_perf;
    rst = 1'b1; cmd_load = 1'b0; cmd_exec = 1'b0; abort_s = 1'b0;
    last_pc = '0; loop_cnt = '0; instr_valid = 1'b0; instr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk_idle("reset");
    chk("reset_perf", 64'(perf), 64'(0));

    // 1: async reset while in LOAD
    step();
    cmd_load = 1'b1; last_pc = 5'd2;
    step();
    cmd_load = 1'b0;
    #2 chk("t1_busy_load", 64'(busy), 64'(1));
    chk("t1_ready_load", 64'(instr_ready), 64'(1));
    #2 rst = 1'b1;
    #1 chk_idle("t1_async");
    step();
    rst = 1'b0;
    step();
    #2 chk_idle("t1_release");

    // 2: load 12 beats with valid gaps
    step();
    cmd_load = 1'b1; last_pc = 5'd2;
    step();
    cmd_load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k % 5 == 2) begin
        #2 chk("t2_gap_we", 64'(conf_we), 64'(0));
        chk("t2_gap_ce", 64'(conf_ce), 64'(0));
        chk("t2_gap_ready", 64'(instr_ready), 64'(1));
        step();
      end
      beat_q.push_back('{we: 4'(1 << (k % 4)), pc: 5'(k / 4), instr: 32'hA0 + 32'(k)});
      load_beat("t2_beat", 32'hA0 + 32'(k));
    end
    #2 chk("t2_done", 64'(done), 64'(1));
    chk("t2_done_we", 64'(conf_we), 64'(0));
    step();
    #2 chk("t2_after_done", 64'(done), 64'(0));
    chk("t2_after_busy", 64'(busy), 64'(0));

    // 3: exec last_pc=2 x3
    step();
    cmd_exec = 1'b1; last_pc = 5'd2; loop_cnt = 16'd3;
    for (int it = 0; it < 3; it++)
      for (int p = 0; p < 3; p++) pc_q.push_back(p);
    step();
    cmd_exec = 1'b0;
    for (int c = 1; c <= 9; c++) exec_cycle("t3_exec");
    #2 chk("t3_drain_re", 64'(conf_re), 64'(0));
    chk("t3_drain_ce", 64'(conf_ce), 64'(1));
    chk("t3_drain_done", 64'(done), 64'(0));
    step();
`ifdef CONF_SEQ_PERF_EN
    exp_perf = 32'd10;
`else
    exp_perf = 32'd0;
`endif
    #2 chk("t3_done_c11", 64'(done), 64'(1));
    chk("t3_perf", 64'(perf), 64'(exp_perf));
    step();
    #2 chk("t3_idle_busy", 64'(busy), 64'(0));
    chk("t3_perf_hold", 64'(perf), 64'(exp_perf));

    // 4: loop_cnt=0, last_pc=0
    cmd_exec = 1'b1; last_pc = 5'd0; loop_cnt = 16'd0;
    pc_q.push_back(0);
    step();
    cmd_exec = 1'b0;
    exec_cycle("t4_exec");
    #2 chk("t4_drain_re", 64'(conf_re), 64'(0));
    chk("t4_drain_ce", 64'(conf_ce), 64'(1));
    step();
`ifdef CONF_SEQ_PERF_EN
    exp_perf = 32'd2;
`else
    exp_perf = 32'd0;
`endif
    #2 chk("t4_done_c3", 64'(done), 64'(1));
    chk("t4_perf", 64'(perf), 64'(exp_perf));
    step();

    // 5: load wins over exec; exec while busy ignored
    cmd_load = 1'b1; cmd_exec = 1'b1; last_pc = 5'd0; loop_cnt = 16'd4;
    step();
    cmd_load = 1'b0;
    #2 chk("t5_load_wins_ready", 64'(instr_ready), 64'(1));
    chk("t5_load_wins_re", 64'(conf_re), 64'(0));
    step();
    #2 chk("t5_busy_exec_ignored", 64'(conf_re), 64'(0));
    chk("t5_still_load", 64'(instr_ready), 64'(1));
    cmd_exec = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat_q.push_back('{we: 4'(1 << k), pc: 5'd0, instr: 32'hB0 + 32'(k)});
      load_beat("t5_beat", 32'hB0 + 32'(k));
    end
    #2 chk("t5_done", 64'(done), 64'(1));
    step();

    // 6a: abort in LOAD blocks the same-cycle beat
    cmd_load = 1'b1; last_pc = 5'd1;
    step();
    cmd_load = 1'b0;
    instr_valid = 1'b1; instr = 32'hDEAD; abort_s = 1'b1;
    #2 chk("t6_abort_ready", 64'(instr_ready), 64'(0));
    chk("t6_abort_we", 64'(conf_we), 64'(0));
    step();
    abort_s = 1'b0; instr_valid = 1'b0;
    #2 chk("t6_load_abort_idle", 64'(busy), 64'(0));

    // 6b: abort in EXEC at pc=1
    cmd_exec = 1'b1; last_pc = 5'd2; loop_cnt = 16'd5;
    pc_q.push_back(0);
    step();
    cmd_exec = 1'b0;
    exec_cycle("t6_exec");
    abort_s = 1'b1;
    #2 chk("t6_abort_pc", 64'(global_pc), 64'(1));
    step();
    abort_s = 1'b0;
    #2 chk_idle("t6_after_abort");
    for (int c = 0; c < 4; c++) begin
      step();
      #2 chk("t6_no_done", 64'(done), 64'(0));
    end

    chk("sb_beats_drained", 64'(beat_q.size()), 64'(0));
    chk("sb_pcs_drained", 64'(pc_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
